// File: rtl/i2c_sim_pkg.sv
// i2c_sim_pkg: shared states, bus constants and address matching for the I2C register slave
package i2c_sim_pkg;
  typedef enum logic [2:0] {IDLE, DEV_ADDR, DEV_ACK, REG_ADDR, WR_DATA, WR_ACK, RD_DATA, RD_ACK} state_e;
  localparam logic I2C_ACK = 1'b0;
  localparam logic I2C_NACK = 1'b1;
  localparam int CNT_W = 4;
  localparam logic [7:0] DEVICE_ADDRESS = 8'h42;
  function automatic logic addr_match(input logic [7:0] b);
    return b[7:1] == DEVICE_ADDRESS[7:1];
  endfunction
endpackage

// File: rtl/i2c_reg_slave_if.sv
// i2c_reg_slave_if: register-file side handshake of the I2C slave
interface i2c_reg_slave_if;
  logic enable;
  logic addr_strobe;
  logic write_strobe;
  logic read_strobe;
  logic [7:0] wdata;
  logic [7:0] rdata;
  modport slave (input enable, rdata, output addr_strobe, write_strobe, read_strobe, wdata);
  modport master (output enable, rdata, input addr_strobe, write_strobe, read_strobe, wdata);
endinterface

// File: rtl/i2c_line_sync.sv
// i2c_line_sync: 2-FF synchronizer with registered level and edge pulses
module i2c_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic line_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);
  logic [1:0] sync_q;
  logic level_q, rise_q, fall_q;
  // reset to the idle-high bus level so release from reset is not seen as an edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= 2'b11;
      level_q <= 1'b1;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], line_i};
      level_q <= sync_q[1];
      rise_q  <= sync_q[1] & ~level_q;
      fall_q  <= ~sync_q[1] & level_q;
    end
  end
  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;
endmodule

// File: rtl/i2c_reg_slave.sv
// i2c_reg_slave: I2C slave front-end presenting pointer, write and read accesses as strobes
module i2c_reg_slave
  import i2c_sim_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  inout  wire  sda_io,
  i2c_reg_slave_if.slave bus
);
  logic scl_lvl, scl_rise, scl_fall, sda_lvl, sda_rise, sda_fall;
  logic start, stop, rd_stb;
  logic [7:0] rx_byte;
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d, tx_q, tx_d, wdata_q, wdata_d;
  logic rw_q, rw_d, oe_q, oe_d, addr_stb_q, addr_stb_d, wr_stb_q, wr_stb_d;

  i2c_line_sync u_scl (.clk(clk), .rst(rst), .line_i(scl_i), .level_o(scl_lvl), .rise_o(scl_rise), .fall_o(scl_fall));
  i2c_line_sync u_sda (.clk(clk), .rst(rst), .line_i(sda_io), .level_o(sda_lvl), .rise_o(sda_rise), .fall_o(sda_fall));

  assign start = sda_fall & scl_lvl;
  assign stop  = sda_rise & scl_lvl;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      tx_q       <= '0;
      wdata_q    <= '0;
      rw_q       <= 1'b0;
      oe_q       <= 1'b0;
      addr_stb_q <= 1'b0;
      wr_stb_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      wdata_q    <= wdata_d;
      rw_q       <= rw_d;
      oe_q       <= oe_d;
      addr_stb_q <= addr_stb_d;
      wr_stb_q   <= wr_stb_d;
    end
  end

  // ACK states use cnt 8 = waiting to drive the 9th bit, cnt 0 = 9th rise seen
  always_comb begin
    rx_byte    = {shift_q[6:0], sda_lvl};
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    wdata_d    = wdata_q;
    rw_d       = rw_q;
    oe_d       = oe_q;
    addr_stb_d = 1'b0;
    wr_stb_d   = 1'b0;
    rd_stb     = 1'b0;
    if (!bus.enable) begin
      state_d = IDLE;
      cnt_d   = '0;
      oe_d    = 1'b0;
    end else if (start || stop) begin
      state_d = start ? DEV_ADDR : IDLE;
      cnt_d   = '0;
      shift_d = '0;
      oe_d    = 1'b0;
    end else begin
      case (state_q)
        DEV_ADDR, REG_ADDR, WR_DATA: if (scl_rise) begin
          shift_d = rx_byte;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(7)) begin
            if (state_q == DEV_ADDR) begin
              rw_d    = sda_lvl;
              state_d = addr_match(rx_byte) ? DEV_ACK : IDLE;
            end else begin
              wdata_d    = rx_byte;
              addr_stb_d = state_q == REG_ADDR;
              wr_stb_d   = state_q == WR_DATA;
              state_d    = WR_ACK;
            end
          end
        end
        DEV_ACK, WR_ACK: begin
          if (scl_fall && cnt_q == CNT_W'(8)) oe_d = 1'b1;
          else if (scl_rise) cnt_d = '0;
          else if (scl_fall && cnt_q == '0) begin
            shift_d = '0;
            if (state_q == DEV_ACK && rw_q) begin
              tx_d    = bus.rdata;
              rd_stb  = 1'b1;
              oe_d    = ~bus.rdata[7];
              state_d = RD_DATA;
            end else begin
              oe_d    = 1'b0;
              state_d = state_q == DEV_ACK ? REG_ADDR : WR_DATA;
            end
          end
        end
        RD_DATA: begin
          if (scl_rise) cnt_d = cnt_q + 1'b1;
          else if (scl_fall && cnt_q == CNT_W'(8)) begin
            oe_d    = 1'b0;
            state_d = RD_ACK;
          end else if (scl_fall) begin
            tx_d = {tx_q[6:0], 1'b0};
            oe_d = ~tx_q[6];
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            cnt_d   = '0;
            state_d = sda_lvl == I2C_ACK ? RD_ACK : IDLE;
          end else if (scl_fall && cnt_q == '0) begin
            tx_d    = bus.rdata;
            rd_stb  = 1'b1;
            oe_d    = ~bus.rdata[7];
            state_d = RD_DATA;
          end
        end
        default: ;
      endcase
    end
  end

  assign sda_io           = oe_q ? 1'b0 : 1'bz;
  assign bus.addr_strobe  = addr_stb_q;
  assign bus.write_strobe = wr_stb_q;
  assign bus.read_strobe  = rd_stb;
  assign bus.wdata        = wdata_q;
endmodule

// File: tb/tb_i2c_reg_slave.sv
// tb_i2c_reg_slave: directed I2C master transactions against i2c_reg_slave
`timescale 1ns/1ps
module tb_i2c_reg_slave;
  import i2c_sim_pkg::*;
  localparam int Q = 50;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scl = 1'b1;
  logic sda_m = 1'b1;
  wire sda;
  int n_chk = 0;
  int n_fail = 0;
  int n_addr = 0, n_wr = 0, n_rd = 0;
  logic [7:0] last_addr = 8'h00, last_wr = 8'h00;

  i2c_reg_slave_if bus();
  i2c_reg_slave dut (.clk(clk), .rst(rst), .scl_i(scl), .sda_io(sda), .bus(bus));

  assign sda = sda_m ? 1'bz : 1'b0;
  pullup (sda);

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.addr_strobe) begin n_addr++; last_addr = bus.wdata; end
    if (bus.write_strobe) begin n_wr++; last_wr = bus.wdata; end
    if (bus.read_strobe) n_rd++;
  end

  task automatic i2c_start();
    sda_m = 1'b1; #Q; scl = 1'b1; #Q; sda_m = 1'b0; #Q; scl = 1'b0; #Q;
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; #Q; scl = 1'b1; #Q; sda_m = 1'b1; #Q;
  endtask

  task automatic write_bit(input logic b);
    sda_m = b; #Q; scl = 1'b1; #(2*Q); scl = 1'b0; #Q;
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; #Q; scl = 1'b1; #Q; b = sda; #Q; scl = 1'b0; #Q;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin read_bit(b); d[i] = b; end
    write_bit(mack);
  endtask

  task automatic test_reset();
    bus.enable = 1'b1;
    bus.rdata = 8'h00;
    #23 rst = 1'b0;
    repeat (4) @(negedge clk);
    n_chk++; if (bus.wdata !== 8'h00) begin n_fail++; $display("FAIL reset_wdata: got %h expected 00", bus.wdata); end
    n_chk++; if ({bus.addr_strobe, bus.write_strobe, bus.read_strobe} !== 3'b000) begin n_fail++; $display("FAIL reset_strobes: got %b expected 000", {bus.addr_strobe, bus.write_strobe, bus.read_strobe}); end
    n_chk++; if (sda !== 1'b1) begin n_fail++; $display("FAIL reset_sda: got %b expected 1", sda); end
    n_chk++; if (dut.state_q !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected IDLE", dut.state_q); end
  endtask

  task automatic test_write();
    logic a0, a1, a2;
    int na = n_addr, nw = n_wr, nr = n_rd;
    i2c_start();
    write_byte(8'h42, a0);
    write_byte(8'h01, a1);
    write_byte(8'h5A, a2);
    i2c_stop();
    #Q;
    n_chk++; if ({a0, a1, a2} !== 3'b000) begin n_fail++; $display("FAIL write_acks: got %b expected 000", {a0, a1, a2}); end
    n_chk++; if (n_addr - na != 1) begin n_fail++; $display("FAIL write_addr_strobe: got %0d cycles expected 1", n_addr - na); end
    n_chk++; if (last_addr !== 8'h01) begin n_fail++; $display("FAIL write_addr_wdata: got %h expected 01", last_addr); end
    n_chk++; if (n_wr - nw != 1) begin n_fail++; $display("FAIL write_data_strobe: got %0d cycles expected 1", n_wr - nw); end
    n_chk++; if (last_wr !== 8'h5A) begin n_fail++; $display("FAIL write_data_wdata: got %h expected 5a", last_wr); end
    n_chk++; if (n_rd != nr) begin n_fail++; $display("FAIL write_no_read: got %0d read strobes expected 0", n_rd - nr); end
  endtask

  task automatic test_read();
    logic a0, a1, a2;
    logic [7:0] b0, b1;
    int na = n_addr, nr = n_rd, nw = n_wr;
    bus.rdata = 8'hA5;
    i2c_start();
    write_byte(8'h42, a0);
    write_byte(8'h00, a1);
    i2c_start();
    write_byte(8'h43, a2);
    read_byte(1'b0, b0);
    read_byte(1'b1, b1);
    n_chk++; if (sda !== 1'b1 || dut.state_q !== IDLE) begin n_fail++; $display("FAIL read_release_after_nack: got sda=%b state=%0d expected sda=1 IDLE", sda, dut.state_q); end
    i2c_stop();
    #Q;
    n_chk++; if ({a0, a1, a2} !== 3'b000) begin n_fail++; $display("FAIL read_acks: got %b expected 000", {a0, a1, a2}); end
    n_chk++; if (b0 !== 8'hA5) begin n_fail++; $display("FAIL read_byte0: got %h expected a5", b0); end
    n_chk++; if (b1 !== 8'hA5) begin n_fail++; $display("FAIL read_byte1: got %h expected a5", b1); end
    n_chk++; if (n_rd - nr != 2) begin n_fail++; $display("FAIL read_strobes: got %0d expected 2", n_rd - nr); end
    n_chk++; if (n_addr - na != 1 || last_addr !== 8'h00) begin n_fail++; $display("FAIL read_pointer: got %0d strobes wdata=%h expected 1 wdata=00", n_addr - na, last_addr); end
    n_chk++; if (n_wr != nw) begin n_fail++; $display("FAIL read_no_write: got %0d write strobes expected 0", n_wr - nw); end
  endtask

  task automatic test_mismatch();
    logic a0, a1;
    int na = n_addr, nw = n_wr, nr = n_rd;
    i2c_start();
    write_byte(8'h44, a0);
    write_byte(8'h01, a1);
    i2c_stop();
    #Q;
    n_chk++; if (a0 !== 1'b1) begin n_fail++; $display("FAIL mismatch_nack: got %b expected 1", a0); end
    n_chk++; if (a1 !== 1'b1) begin n_fail++; $display("FAIL mismatch_silent: got %b expected 1", a1); end
    n_chk++; if (n_addr != na || n_wr != nw || n_rd != nr) begin n_fail++; $display("FAIL mismatch_strobes: got %0d/%0d/%0d expected 0/0/0", n_addr - na, n_wr - nw, n_rd - nr); end
  endtask

  task automatic test_enable();
    logic a0, a1, a2;
    int na = n_addr, nw = n_wr;
    bus.enable = 1'b0;
    i2c_start();
    write_byte(8'h42, a0);
    write_byte(8'h01, a1);
    write_byte(8'h5A, a2);
    i2c_stop();
    #Q;
    n_chk++; if ({a0, a1, a2} !== 3'b111) begin n_fail++; $display("FAIL disabled_acks: got %b expected 111", {a0, a1, a2}); end
    n_chk++; if (n_addr != na || n_wr != nw) begin n_fail++; $display("FAIL disabled_strobes: got %0d/%0d expected 0/0", n_addr - na, n_wr - nw); end
    bus.enable = 1'b1;
    #Q;
    i2c_start();
    write_byte(8'h42, a0);
    write_byte(8'h07, a1);
    i2c_stop();
    #Q;
    n_chk++; if ({a0, a1} !== 2'b00) begin n_fail++; $display("FAIL reenabled_acks: got %b expected 00", {a0, a1}); end
    n_chk++; if (n_addr - na != 1 || last_addr !== 8'h07) begin n_fail++; $display("FAIL reenabled_pointer: got %0d strobes wdata=%h expected 1 wdata=07", n_addr - na, last_addr); end
  endtask

  task automatic test_stop_mid_byte();
    logic a0;
    int na = n_addr, nw = n_wr;
    i2c_start();
    write_byte(8'h42, a0);
    for (int i = 7; i >= 4; i--) write_bit(1'(8'h03 >> i));
    i2c_stop();
    #Q;
    n_chk++; if (a0 !== 1'b0) begin n_fail++; $display("FAIL stopmid_dev_ack: got %b expected 0", a0); end
    n_chk++; if (n_addr != na || n_wr != nw) begin n_fail++; $display("FAIL stopmid_strobes: got %0d/%0d expected 0/0", n_addr - na, n_wr - nw); end
    n_chk++; if (dut.state_q !== IDLE || sda !== 1'b1) begin n_fail++; $display("FAIL stopmid_idle: got state=%0d sda=%b expected IDLE sda=1", dut.state_q, sda); end
    n_chk++; if (bus.wdata !== 8'h07) begin n_fail++; $display("FAIL stopmid_wdata_hold: got %h expected 07", bus.wdata); end
  endtask

  task automatic test_reset_mid_read();
    logic a0, a1;
    bus.rdata = 8'h3C;
    i2c_start();
    write_byte(8'h43, a0);
    sda_m = 1'b1; #Q;
    n_chk++; if (a0 !== 1'b0 || sda !== 1'b0) begin n_fail++; $display("FAIL rstread_driving: got ack=%b sda=%b expected 0 0", a0, sda); end
    rst = 1'b1;
    #1;
    n_chk++; if (sda !== 1'b1) begin n_fail++; $display("FAIL rstread_sda_release: got %b expected 1", sda); end
    #9 rst = 1'b0;
    @(negedge clk);
    n_chk++; if (bus.wdata !== 8'h00) begin n_fail++; $display("FAIL rstread_wdata: got %h expected 00", bus.wdata); end
    n_chk++; if ({bus.addr_strobe, bus.write_strobe, bus.read_strobe} !== 3'b000) begin n_fail++; $display("FAIL rstread_strobes: got %b expected 000", {bus.addr_strobe, bus.write_strobe, bus.read_strobe}); end
    i2c_stop();
    i2c_start();
    write_byte(8'h42, a1);
    i2c_stop();
    n_chk++; if (a1 !== 1'b0) begin n_fail++; $display("FAIL rstread_next_ack: got %b expected 0", a1); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_mismatch();
    test_enable();
    test_stop_mid_byte();
    test_reset_mid_read();
    #(4*Q);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
